// File: rtl/mem_arbiter.sv
// Two-port arbiter for the single-ported program/data memory (CPU port A, loader/debug port B).
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default build gives port A fixed priority.
module mem_arbiter #(
    parameter int WORD_SIZE     = 16,
    parameter int MEM_ADDR_SIZE = 8,
    parameter int MEM_LATENCY   = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     a_req,
    input  logic                     a_write,
    input  logic [MEM_ADDR_SIZE-1:0] a_addr,
    input  logic [WORD_SIZE-1:0]     a_wdata,
    output logic                     a_ack,
    output logic [WORD_SIZE-1:0]     a_rdata,
    input  logic                     b_req,
    input  logic                     b_write,
    input  logic [MEM_ADDR_SIZE-1:0] b_addr,
    input  logic [WORD_SIZE-1:0]     b_wdata,
    output logic                     b_ack,
    output logic [WORD_SIZE-1:0]     b_rdata,
    output logic [MEM_ADDR_SIZE-1:0] mem_address,
    output logic [WORD_SIZE-1:0]     mem_write_data,
    output logic                     mem_read,
    output logic                     mem_write,
    input  logic [WORD_SIZE-1:0]     mem_read_data,
    output logic                     busy,
    output logic                     owner
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

    state_t                   state;
    state_t                   state_next;
    logic                     grant_b;
    logic                     lat_write;
    logic [MEM_ADDR_SIZE-1:0] lat_addr;
    logic [WORD_SIZE-1:0]     lat_wdata;
    logic [CNT_W-1:0]         wait_cnt;

    always_comb begin
        state_next = state;
        grant_b    = 1'b0;
`ifdef MEM_ARB_RR_EN
        // On a tie the port that did not hold the memory last time goes next.
        grant_b = b_req && (!a_req || !owner);
`else
        grant_b = b_req && !a_req;
`endif
        case (state)
            IDLE:    if (a_req || b_req) state_next = ACCESS;
            ACCESS:  state_next = lat_write ? ACK : WAIT;
            WAIT:    if (wait_cnt == WAIT_LAST) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            owner     <= 1'b0;
            wait_cnt  <= '0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            if (state == IDLE && (a_req || b_req)) begin
                owner     <= grant_b;
                lat_write <= grant_b ? b_write : a_write;
                lat_addr  <= grant_b ? b_addr  : a_addr;
                lat_wdata <= grant_b ? b_wdata : a_wdata;
            end
            if (state == ACCESS)    wait_cnt <= '0;
            else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
            // Read data is valid at the end of the last latency cycle.
            if (state == WAIT && wait_cnt == WAIT_LAST) begin
                if (owner) b_rdata <= mem_read_data;
                else       a_rdata <= mem_read_data;
            end
        end
    end

    assign mem_address    = lat_addr;
    assign mem_write_data = lat_wdata;
    assign mem_read       = (state == ACCESS) && !lat_write;
    assign mem_write      = (state == ACCESS) &&  lat_write;
    assign busy           = (state != IDLE);
    assign a_ack          = (state == ACK) && !owner;
    assign b_ack          = (state == ACK) &&  owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: latency-1 instance plus a latency-3 instance.
// Expectations follow the build: MEM_ARB_RR_EN selects round-robin expectations.
module tb_mem_arbiter;

    logic        clock;
    logic        reset;
    logic        a_req, a_write, b_req, b_write;
    logic [7:0]  a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic        a_ack, b_ack, mem_read, mem_write, busy, owner;
    logic [15:0] a_rdata, b_rdata, mem_write_data, mem_read_data;
    logic [7:0]  mem_address;

    logic        a_req3;
    logic [7:0]  a_addr3;
    logic        a_ack3, b_ack3, mem_read3, mem_write3, busy3, owner3;
    logic [15:0] a_rdata3, b_rdata3, mem_write_data3, mem_read_data3;
    logic [7:0]  mem_address3;

    int testsRun = 0;
    int testsFailed = 0;
    logic rrBuild;
    logic modelOwner;
    logic firstB;
    logic expPort;

    mem_arbiter #(.WORD_SIZE(16), .MEM_ADDR_SIZE(8), .MEM_LATENCY(1)) dut (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data),
        .busy(busy), .owner(owner)
    );

    mem_arbiter #(.WORD_SIZE(16), .MEM_ADDR_SIZE(8), .MEM_LATENCY(3)) dut3 (
        .clock(clock), .reset(reset),
        .a_req(a_req3), .a_write(1'b0), .a_addr(a_addr3), .a_wdata(16'h0000),
        .a_ack(a_ack3), .a_rdata(a_rdata3),
        .b_req(1'b0), .b_write(1'b0), .b_addr(8'h00), .b_wdata(16'h0000),
        .b_ack(b_ack3), .b_rdata(b_rdata3),
        .mem_address(mem_address3), .mem_write_data(mem_write_data3),
        .mem_read(mem_read3), .mem_write(mem_write3), .mem_read_data(mem_read_data3),
        .busy(busy3), .owner(owner3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic applyStimulus(input logic port, input logic write, input logic [7:0] addr, input logic [15:0] wdata);
        if (port) begin
            b_req = 1'b1; b_write = write; b_addr = addr; b_wdata = wdata;
        end else begin
            a_req = 1'b1; a_write = write; a_addr = addr; a_wdata = wdata;
        end
    endtask

    task automatic pulseReset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
`ifdef MEM_ARB_RR_EN
        rrBuild = 1'b1;
`else
        rrBuild = 1'b0;
`endif
        reset = 1'b0;
        a_req = 0; a_write = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_write = 0; b_addr = 0; b_wdata = 0;
        mem_read_data = 0; a_req3 = 0; a_addr3 = 0; mem_read_data3 = 0;
        tick(); tick();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_mem_rw", {mem_read, mem_write}, 0);
        checkOutput("rst_acks", {a_ack, b_ack}, 0);
        checkOutput("rst_owner", owner, 0);
        checkOutput("rst_addr_data", {mem_address, mem_write_data}, 0);
        checkOutput("rst_rdata", {a_rdata, b_rdata}, 0);
        reset = 1'b1;
        tick();

        // A reads 0x05, memory returns 0x1234
        applyStimulus(1'b0, 1'b0, 8'h05, 16'h0000);
        mem_read_data = 16'h1234;
        tick();
        checkOutput("t1_c1_read", {mem_read, mem_write}, 2'b10);
        checkOutput("t1_c1_addr", mem_address, 8'h05);
        checkOutput("t1_c1_busy", busy, 1);
        tick();
        checkOutput("t1_c2_noread", mem_read, 0);
        checkOutput("t1_c2_noack", a_ack, 0);
        tick();
        checkOutput("t1_c3_ack", {a_ack, b_ack}, 2'b10);
        checkOutput("t1_c3_rdata", a_rdata, 16'h1234);
        a_req = 1'b0;
        tick();
        checkOutput("t1_idle", {busy, a_ack}, 0);

        // B writes 0xBEEF to 0x10
        applyStimulus(1'b1, 1'b1, 8'h10, 16'hBEEF);
        mem_read_data = 16'h9999;
        tick();
        checkOutput("t2_c1_write", {mem_read, mem_write}, 2'b01);
        checkOutput("t2_c1_addr", mem_address, 8'h10);
        checkOutput("t2_c1_data", mem_write_data, 16'hBEEF);
        checkOutput("t2_c1_owner", owner, 1);
        tick();
        checkOutput("t2_c2_ack", {a_ack, b_ack}, 2'b01);
        checkOutput("t2_c2_norw", {mem_read, mem_write}, 0);
        checkOutput("t2_b_rdata_kept", b_rdata, 16'h0000);
        checkOutput("t2_a_rdata_kept", a_rdata, 16'h1234);
        b_req = 1'b0;
        tick();
        checkOutput("t2_idle", busy, 0);

        // Simultaneous reads from both ports, fresh owner after reset
        pulseReset();
        firstB = rrBuild;
        applyStimulus(1'b0, 1'b0, 8'h20, 16'h0000);
        applyStimulus(1'b1, 1'b0, 8'h30, 16'h0000);
        mem_read_data = 16'h5555;
        tick();
        checkOutput("t3_first_owner", owner, firstB);
        checkOutput("t3_first_addr", mem_address, firstB ? 8'h30 : 8'h20);
        tick();
        tick();
        checkOutput("t3_first_ack", {a_ack, b_ack}, firstB ? 2'b01 : 2'b10);
        if (firstB) b_req = 1'b0; else a_req = 1'b0;
        tick();
        checkOutput("t3_gap_idle", busy, 0);
        tick();
        mem_read_data = 16'h6666;
        checkOutput("t3_second_owner", owner, !firstB);
        checkOutput("t3_second_addr", mem_address, firstB ? 8'h20 : 8'h30);
        tick();
        tick();
        checkOutput("t3_second_ack", {a_ack, b_ack}, firstB ? 2'b10 : 2'b01);
        checkOutput("t3_rdata", {a_rdata, b_rdata}, firstB ? {16'h6666, 16'h5555} : {16'h5555, 16'h6666});
        a_req = 1'b0; b_req = 1'b0;
        modelOwner = !firstB;
        tick();

        // Both ports hold write requests across three transactions
        applyStimulus(1'b0, 1'b1, 8'h40, 16'hAAAA);
        applyStimulus(1'b1, 1'b1, 8'h50, 16'hBBBB);
        for (int k = 0; k < 3; k++) begin
            expPort = rrBuild ? !modelOwner : 1'b0;
            tick();
            checkOutput($sformatf("t4_%0d_owner", k), owner, expPort);
            checkOutput($sformatf("t4_%0d_wdata", k), mem_write_data, expPort ? 16'hBBBB : 16'hAAAA);
            tick();
            checkOutput($sformatf("t4_%0d_ack", k), {a_ack, b_ack}, expPort ? 2'b01 : 2'b10);
            modelOwner = expPort;
            tick();
            checkOutput($sformatf("t4_%0d_idle", k), busy, 0);
        end
        a_req = 1'b0; b_req = 1'b0;
        tick();

        // Reset during WAIT aborts the read; held a_req is served again
        applyStimulus(1'b0, 1'b0, 8'h60, 16'h0000);
        mem_read_data = 16'h7777;
        tick();
        tick();
        checkOutput("t5_in_wait", {busy, mem_read}, 2'b10);
        reset = 1'b0;
        #1;
        checkOutput("t5_rst_now", {busy, mem_read, a_ack}, 0);
        tick();
        checkOutput("t5_no_ack", {a_ack, b_ack, busy}, 0);
        checkOutput("t5_rdata_clr", a_rdata, 16'h0000);
        reset = 1'b1;
        tick();
        checkOutput("t5_reserve_read", {mem_read, mem_address}, {1'b1, 8'h60});
        tick();
        tick();
        checkOutput("t5_reserve_ack", {a_ack, a_rdata}, {1'b1, 16'h7777});
        a_req = 1'b0;
        tick();

        // Latency-3 instance: ack in cycle 5, data taken at end of cycle 4
        a_req3 = 1'b1; a_addr3 = 8'h42; mem_read_data3 = 16'h1111;
        tick();
        checkOutput("t6_c1_read", {mem_read3, mem_address3}, {1'b1, 8'h42});
        tick();
        tick();
        checkOutput("t6_c3_noack", a_ack3, 0);
        tick();
        mem_read_data3 = 16'hCAFE;
        checkOutput("t6_c4_noack", {a_ack3, busy3}, 2'b01);
        tick();
        checkOutput("t6_c5_ack", a_ack3, 1);
        checkOutput("t6_c5_rdata", a_rdata3, 16'hCAFE);
        mem_read_data3 = 16'h2222;
        a_req3 = 1'b0;
        tick();
        checkOutput("t6_idle", {a_ack3, busy3, a_rdata3}, {2'b00, 16'hCAFE});

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
